// File: rtl/serial_rx_sipo.sv
// Receiving end of the single-wire framed serial link: start 0, WIDTH data bits LSB first, stop 1.
// Good words are presented on dout with a valid/ack handshake; framing errors and overruns are flagged.
module serial_rx_sipo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             ack,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Frame sequencing: the start bit is consumed in IDLE, so DATA sees exactly WIDTH edges.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (!sin) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_d[cnt_q] = sin;
        cnt_d          = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = STOP;
        end
      end
      STOP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A load on the stop edge overrides an ack clear on the same edge, keeping valid high with new data.
  always_comb begin
    dout_d      = dout_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = 1'b0;
    if (ack) begin
      valid_d = 1'b0;
    end
    if (state_q == STOP) begin
      if (sin) begin
        if (!valid_q || ack) begin
          dout_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  assign busy      = (state_q == DATA) || (state_q == STOP);
  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_serial_rx_sipo.sv
// Self-checking bench for serial_rx_sipo: directed frames from the test plan plus random frames,
// checked every cycle against a frame-level model of the handshake rules.
module tb_serial_rx_sipo;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             sin;
  logic             ack;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             frame_err;
  logic             overrun;
  logic             busy;

  int compared   = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] expDout;
  logic             expValid;
  logic             expFerr;
  logic             expOverrun;

  serial_rx_sipo #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .ack       (ack),
    .dout      (dout),
    .valid     (valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic expBusy);
    checkOutput({tag, ".dout"}, 32'(dout), 32'(expDout));
    checkOutput({tag, ".valid"}, 32'(valid), 32'(expValid));
    checkOutput({tag, ".frame_err"}, 32'(frame_err), 32'(expFerr));
    checkOutput({tag, ".overrun"}, 32'(overrun), 32'(expOverrun));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(expBusy));
  endtask

  task automatic modelReset();
    expDout    = '0;
    expValid   = 1'b0;
    expFerr    = 1'b0;
    expOverrun = 1'b0;
  endtask

  // One clock edge: drive at negedge, sample 1 time unit after posedge, advance the model.
  // isStop marks the edge where the bench knows it is sending the stop bit of frame 'word'.
  task automatic applyStimulus(input string tag, input logic s, input logic a, input bit isStop,
                               input logic [WIDTH-1:0] word, input logic expBusy);
    @(negedge clk);
    sin = s;
    ack = a;
    @(posedge clk);
    #1;
    if (isStop && s) begin
      expFerr = 1'b0;
      if (!expValid || a) begin
        expDout  = word;
        expValid = 1'b1;
      end else begin
        expOverrun = 1'b1;
      end
    end else begin
      expFerr = isStop && !s;
      if (a) expValid = 1'b0;
    end
    checkAll(tag, expBusy);
  endtask

  task automatic sendFrame(input string tag, input logic [WIDTH-1:0] word, input logic stopBit,
                           input logic ackStop, input bit randAck);
    applyStimulus(tag, 1'b0, randAck && ($urandom_range(0, 3) == 0), 1'b0, word, 1'b1);
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(tag, word[i], randAck && ($urandom_range(0, 3) == 0), 1'b0, word, 1'b1);
    end
    applyStimulus(tag, stopBit, ackStop, 1'b1, word, 1'b0);
  endtask

  task automatic idle(input string tag, input int n, input logic a);
    for (int i = 0; i < n; i++) begin
      applyStimulus(tag, 1'b1, a, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic pulseReset(input int cycles);
    @(negedge clk);
    sin = 1'b1;
    ack = 1'b0;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll("async_rst", 1'b0);
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    modelReset();
    rst = 1'b1;
    sin = 1'b1;
    ack = 1'b0;

    // Reset held with idle line
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkAll("reset_idle", 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    idle("post_reset", 3, 1'b0);

    // Single good frame, hold, then ack
    sendFrame("frame_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    checkOutput("a5_dout_const", 32'(dout), 32'h0000_00A5);
    checkOutput("a5_valid_const", 32'(valid), 32'h1);
    idle("a5_hold", 4, 1'b0);
    idle("a5_ack", 1, 1'b1);
    checkOutput("a5_valid_cleared", 32'(valid), 32'h0);
    idle("a5_after", 2, 1'b0);

    // Framing error then recovery
    sendFrame("frame_3c_bad", 8'h3C, 1'b0, 1'b0, 1'b0);
    checkOutput("ferr_pulse", 32'(frame_err), 32'h1);
    idle("ferr_gap", 1, 1'b0);
    checkOutput("ferr_one_cycle", 32'(frame_err), 32'h0);
    sendFrame("frame_81", 8'h81, 1'b1, 1'b0, 1'b0);
    checkOutput("f81_dout_const", 32'(dout), 32'h0000_0081);
    idle("f81_ack", 1, 1'b1);

    // Back-to-back without ack: second word dropped
    sendFrame("b2b_11", 8'h11, 1'b1, 1'b0, 1'b0);
    sendFrame("b2b_22", 8'h22, 1'b1, 1'b0, 1'b0);
    checkOutput("ovr_dout_const", 32'(dout), 32'h0000_0011);
    checkOutput("ovr_flag_const", 32'(overrun), 32'h1);
    idle("ovr_sticky", 3, 1'b1);

    // Back-to-back with ack on the second stop edge
    pulseReset(2);
    idle("b2b_ack_pre", 2, 1'b0);
    sendFrame("b2b_ack_11", 8'h11, 1'b1, 1'b0, 1'b0);
    sendFrame("b2b_ack_22", 8'h22, 1'b1, 1'b1, 1'b0);
    checkOutput("b2b_ack_dout_const", 32'(dout), 32'h0000_0022);
    checkOutput("b2b_ack_ovr_const", 32'(overrun), 32'h0);
    idle("b2b_ack_clear", 1, 1'b1);

    // Reset after the 4th data bit of 0xFF
    applyStimulus("abort_start", 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus("abort_data", 1'b1, 1'b0, 1'b0, 8'hFF, 1'b1);
    pulseReset(2);
    idle("abort_idle", 3, 1'b0);
    sendFrame("frame_5a", 8'h5A, 1'b1, 1'b0, 1'b0);
    checkOutput("f5a_dout_const", 32'(dout), 32'h0000_005A);
    idle("f5a_ack", 1, 1'b1);

    // Line stuck low for 25 edges then released: two bad frames, then a frame whose
    // last four data bits are the released 1s
    sendFrame("stuck_1", 8'h00, 1'b0, 1'b0, 1'b0);
    sendFrame("stuck_2", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("stuck_valid_low", 32'(valid), 32'h0);
    sendFrame("stuck_tail", 8'hF0, 1'b1, 1'b0, 1'b0);
    idle("stuck_ack", 1, 1'b1);

    // Random frames, stop bits, gaps and acks
    for (int f = 0; f < 40; f++) begin
      w = WIDTH'($urandom);
      sendFrame("rand", w, ($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), 1'b1);
      idle("rand_gap", $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_rx_sipo.md
# serial_rx_sipo

Synchronous serial-in, parallel-out frame receiver: the receiving end of the team's single-wire, one-bit-per-clock framed serial link (idle high, start 0, WIDTH data bits LSB first, stop 1). It shifts the line into a register, checks framing, and presents each good word on a parallel port with a valid/ack handshake. It sits between a serial transmitter on the same clock and a parallel consumer (register file, FIFO). It also flags framing errors and overruns.

## Interface
- WIDTH, 8, data bits per frame (2..32)
- clk  input  1  rising-edge clock; the line is sampled every edge
- rst  input  1  asynchronous, active-high reset; clears all state immediately
- sin  input  1  serial line, synchronous to clk, idle = 1
- ack  input  1  consumer accepts dout; meaningful only while valid = 1
- dout  output  WIDTH  last accepted word, LSB = first data bit received
- valid  output  1  dout holds an unconsumed word
- frame_err  output  1  one-cycle pulse: stop bit sampled as 0
- overrun  output  1  sticky: a good frame was dropped because valid was still set
- busy  output  1  1 in DATA or STOP state

## Operation
- Reset values: state = IDLE, shift register = 0, bit counter = 0, dout = 0, valid = 0, frame_err = 0, overrun = 0, busy = 0.
- IDLE:
  - sin = 0 at an edge is the start bit: go to DATA and set counter = 0.
  - sin = 1: stay in IDLE.
- DATA:
  - Each edge shifts sin into bit position counter, LSB first, then increments counter.
  - After WIDTH bits, go to STOP. The counter is WIDTH-bit-index wide and is not used outside DATA.
- STOP:
  - sin = 1 (good frame):
    - If valid = 0, or ack = 1 in the same cycle: load dout with the shift register and set valid = 1.
    - Otherwise, keep the old dout and set overrun = 1.
  - sin = 0 (bad frame): pulse frame_err for one cycle. dout and valid are unchanged; the frame is discarded.
  - Either way, return to IDLE.
- Handshake:
  - valid stays 1 until an edge where ack = 1. That edge clears valid, unless the same edge loads a new word, in which case valid stays 1 with the new data.
  - ack while valid = 0 is ignored.
  - dout is stable whenever valid = 1.
- overrun clears only on rst.
- Back-to-back frames: a start bit sampled on the edge directly after the STOP edge is accepted; no idle gap is required.
- A line stuck at 0 is handled as follows: the frame completes with frame_err, then the next 0 is taken as a new start bit.

## Timing
- A frame is 1 + WIDTH + 1 edges. Start bit at edge n, data bits at edges n+1 .. n+WIDTH, stop bit at edge n+WIDTH+1.
- valid and dout update on edge n+WIDTH+1. Receive latency is therefore WIDTH+1 cycles from the start-bit edge.
- frame_err is high for exactly the cycle after edge n+WIDTH+1.
- busy is 1 from after edge n until after edge n+WIDTH+1.
- ack takes effect on the edge it is sampled at; valid falls after that edge.
- Reset mid-frame: all outputs go to their reset values asynchronously and the partial frame is lost. The first start bit accepted is the first sin = 0 sampled at an edge after rst deasserts.

## Test plan
- Reset then idle: assert rst with sin = 1 for 20 cycles, no ack -> dout = 0, valid = 0, frame_err = 0, overrun = 0, busy = 0 throughout.
- Single good frame, WIDTH = 8: drive 0, the bits of 0xA5 LSB first, then 1 -> valid = 1 and dout = 0xA5 after the 10th edge. Hold ack = 0 -> both stay put. Pulse ack = 1 -> valid = 0 after that edge.
- Framing error: a frame carrying 0x3C with stop = 0 -> frame_err high for exactly 1 cycle, valid stays 0, next good frame 0x81 is received correctly.
- Back-to-back plus overrun: frames 0x11 and 0x22 with no gap and no ack -> dout = 0x11, valid = 1, overrun = 1 after the second frame. Repeat with ack asserted on the second STOP edge -> dout = 0x22, valid = 1, overrun = 0.
- Reset mid-frame: assert rst after the 4th data bit of 0xFF, release, send 0x5A -> no output from the aborted frame; dout = 0x5A, valid = 1.
- Stuck-low line: sin = 0 for 25 cycles, then 1 -> frame_err pulses at each STOP edge, valid stays 0, no lockup in DATA.
